// File: rtl/display_bcd_driver.sv
// Drives eight 7-segment digits from the CPU display word, either as raw hex
// nibbles or as unsigned decimal via a sequential shift-add-3 converter.
module display_bcd_driver #(
  parameter bit BLANK_LEADING  = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] display,
  input  logic        dec_mode,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DIGITS = 10;
  localparam int unsigned SHOWN  = 8;
  localparam int unsigned BCD_W  = DIGITS * 4;
  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WIDE_W = BCD_W + DATA_W;

  localparam logic [SEG_W-1:0] SEG_ZERO  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [SEG_W-1:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Active-low glyph table; polarity is applied afterwards.
  function automatic logic [SEG_W-1:0] seg_low(input logic [3:0] d);
    logic [SEG_W-1:0] p;
    case (d)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return SEG_ACTIVE_LOW ? p : ~p;
  endfunction

  state_t                       state_q, state_d;
  logic [DATA_W-1:0]            last_value_q, last_value_d;
  logic                         last_mode_q, last_mode_d;
  logic [DATA_W-1:0]            shift_q, shift_d;
  logic [BCD_W-1:0]             bcd_q, bcd_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [SHOWN-1:0][SEG_W-1:0]  hex_q, hex_d;
  logic                         busy_q, busy_d;
  logic                         ovf_q, ovf_d;

  logic [BCD_W-1:0]             bcd_adj;
  logic [WIDE_W-1:0]            shifted;
  int                           top_digit;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_value_q <= '0;
      last_mode_q  <= 1'b0;
      shift_q      <= '0;
      bcd_q        <= '0;
      bit_cnt_q    <= '0;
      hex_q        <= {SHOWN{SEG_ZERO}};
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_value_q <= last_value_d;
      last_mode_q  <= last_mode_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      bit_cnt_q    <= bit_cnt_d;
      hex_q        <= hex_d;
      busy_q       <= busy_d;
      ovf_q        <= ovf_d;
    end
  end

  // Next-state, conversion step and display latch.
  always_comb begin
    state_d      = state_q;
    last_value_d = last_value_q;
    last_mode_d  = last_mode_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    bit_cnt_d    = bit_cnt_q;
    hex_d        = hex_q;
    ovf_d        = ovf_q;
    bcd_adj      = bcd_q;
    shifted      = '0;
    top_digit    = 0;

    case (state_q)
      IDLE: begin
        if ((display != last_value_q) || (dec_mode != last_mode_q)) begin
          last_value_d = display;
          last_mode_d  = dec_mode;
          if (dec_mode) begin
            shift_d   = display;
            bcd_d     = '0;
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end else begin
            state_d = LATCH;
          end
        end
      end

      SHIFT: begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (bcd_adj[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
          end
        end
        shifted   = {bcd_adj, shift_q} << 1;
        bcd_d     = shifted[WIDE_W-1:DATA_W];
        shift_d   = shifted[DATA_W-1:0];
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = LATCH;
        end
      end

      LATCH: begin
        if (last_mode_q) begin
          // Highest nonzero shown digit; everything above it may be blanked.
          for (int n = 0; n < int'(SHOWN); n++) begin
            if (bcd_q[4*n +: 4] != 4'd0) begin
              top_digit = n;
            end
          end
          for (int n = 0; n < int'(SHOWN); n++) begin
            if (BLANK_LEADING && (n > top_digit)) begin
              hex_d[n] = SEG_BLANK;
            end else begin
              hex_d[n] = seg_low(bcd_q[4*n +: 4]);
            end
          end
          ovf_d = |bcd_q[BCD_W-1:SHOWN*4];
        end else begin
          for (int n = 0; n < int'(SHOWN); n++) begin
            hex_d[n] = seg_low(last_value_q[4*n +: 4]);
          end
          ovf_d = 1'b0;
        end
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign HEX0     = hex_q[0];
  assign HEX1     = hex_q[1];
  assign HEX2     = hex_q[2];
  assign HEX3     = hex_q[3];
  assign HEX4     = hex_q[4];
  assign HEX5     = hex_q[5];
  assign HEX6     = hex_q[6];
  assign HEX7     = hex_q[7];
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_bcd_driver.sv
// Self-checking bench for display_bcd_driver: directed scenarios plus random
// values compared against an arithmetic reference of the displayed digits.
module tb_display_bcd_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] display = '0;
  logic        dec_mode = 1'b0;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic        busy, overflow;

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] exp_hex [8];
  logic       exp_ovf;

  display_bcd_driver dut (
    .clk(clk), .rst_n(rst_n), .display(display), .dec_mode(dec_mode),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7),
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [6:0] act_hex(input int n);
    case (n)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      5: return HEX5;
      6: return HEX6;
      default: return HEX7;
    endcase
  endfunction

  // Reference: what the eight digits should show for a given value and mode.
  task automatic model(input logic [31:0] v, input logic m);
    longint unsigned val, low, p;
    int d [8];
    int top;
    if (!m) begin
      for (int n = 0; n < 8; n++) exp_hex[n] = seg_tab[int'((v >> (4 * n)) & 32'hF)];
      exp_ovf = 1'b0;
    end else begin
      val = longint'(v);
      exp_ovf = (val >= 64'd100000000);
      low = val % 64'd100000000;
      p = 1;
      top = 0;
      for (int n = 0; n < 8; n++) begin
        d[n] = int'((low / p) % 64'd10);
        p = p * 10;
        if (d[n] != 0) top = n;
      end
      for (int n = 0; n < 8; n++) exp_hex[n] = (n > top) ? 7'h7F : seg_tab[d[n]];
    end
  endtask

  // Present inputs, let one edge capture them, then count edges until idle.
  task automatic drive_and_wait(input logic [31:0] v, input logic m, output int lat);
    @(negedge clk);
    display = v;
    dec_mode = m;
    @(posedge clk);
    #1;
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    display = '0;
    dec_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else n_pass++;
    end
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== 7'h40) $display("FAIL reset_hex%0d: got %h want 40", n, act_hex(n));
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_hex_mode();
    logic [6:0] want [8] = '{7'h0E, 7'h06, 7'h06, 7'h03, 7'h21, 7'h08, 7'h06, 7'h21};
    int lat;
    drive_and_wait(32'hDEADBEEF, 1'b0, lat);
    n_total++;
    if (lat !== 1) $display("FAIL hex_latency: got %0d want 1", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== want[n]) $display("FAIL hex_hex%0d: got %h want %h", n, act_hex(n), want[n]);
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b0) $display("FAIL hex_ovf: got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_decimal();
    logic [6:0] want [8] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    int lat;
    drive_and_wait(32'd1234, 1'b1, lat);
    n_total++;
    if (lat !== 33) $display("FAIL dec_latency: got %0d want 33", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== want[n]) $display("FAIL dec1234_hex%0d: got %h want %h", n, act_hex(n), want[n]);
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b0) $display("FAIL dec1234_ovf: got %b want 0", overflow);
    else n_pass++;
  endtask

  task automatic test_max_value();
    int lat;
    drive_and_wait(32'hFFFFFFFF, 1'b1, lat);
    model(32'hFFFFFFFF, 1'b1);
    n_total++;
    if (lat !== 33) $display("FAIL max_latency: got %0d want 33", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== exp_hex[n]) $display("FAIL max_hex%0d: got %h want %h", n, act_hex(n), exp_hex[n]);
      else n_pass++;
    end
    n_total++;
    if (overflow !== 1'b1) $display("FAIL max_ovf: got %b want 1", overflow);
    else n_pass++;
  endtask

  task automatic test_mid_change();
    int lat;
    @(negedge clk);
    display = 32'd99;
    dec_mode = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    display = 32'd7;
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    model(32'd99, 1'b1);
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== exp_hex[n]) $display("FAIL mid99_hex%0d: got %h want %h", n, act_hex(n), exp_hex[n]);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL mid_restart_busy: got %b want 1", busy);
    else n_pass++;
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_total++;
    if (lat !== 33) $display("FAIL mid_restart_latency: got %0d want 33", lat);
    else n_pass++;
    model(32'd7, 1'b1);
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== exp_hex[n]) $display("FAIL mid7_hex%0d: got %h want %h", n, act_hex(n), exp_hex[n]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    @(negedge clk);
    display = 32'd12345678;
    dec_mode = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== 7'h40) $display("FAIL rstmid_hex%0d: got %h want 40", n, act_hex(n));
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rstmid_flags: got busy=%b ovf=%b want 0 0", busy, overflow);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL rstmid_reconvert_busy: got %b want 1", busy);
    else n_pass++;
    lat = 0;
    while (busy && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    model(32'd12345678, 1'b1);
    n_total++;
    if (lat !== 33) $display("FAIL rstmid_latency: got %0d want 33", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== exp_hex[n]) $display("FAIL rstmid_final_hex%0d: got %h want %h", n, act_hex(n), exp_hex[n]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_toggle();
    int lat;
    drive_and_wait(32'd12345678, 1'b0, lat);
    model(32'd12345678, 1'b0);
    n_total++;
    if (lat !== 1) $display("FAIL toggle_hex_latency: got %0d want 1", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== exp_hex[n]) $display("FAIL toggle_hex%0d: got %h want %h", n, act_hex(n), exp_hex[n]);
      else n_pass++;
    end
    drive_and_wait(32'd0, 1'b1, lat);
    n_total++;
    if (lat !== 33) $display("FAIL zero_dec_latency: got %0d want 33", lat);
    else n_pass++;
    for (int n = 0; n < 8; n++) begin
      n_total++;
      if (act_hex(n) !== ((n == 0) ? 7'h40 : 7'h7F))
        $display("FAIL zero_dec_hex%0d: got %h want %h", n, act_hex(n), (n == 0) ? 7'h40 : 7'h7F);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] prev_v = 32'd0;
    logic        prev_m = 1'b1;
    logic [31:0] v;
    logic        m;
    int          lat, want_lat;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: v = $urandom;
        1: v = $urandom_range(0, 999);
        2: v = 32'd100000000;
        3: v = 32'd99999999;
        4: v = prev_v;
        default: v = $urandom_range(0, 99999999);
      endcase
      m = 1'($urandom_range(0, 1));
      want_lat = (v == prev_v && m == prev_m) ? 0 : (m ? 33 : 1);
      drive_and_wait(v, m, lat);
      model(v, m);
      n_total++;
      if (lat !== want_lat) $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, want_lat);
      else n_pass++;
      for (int n = 0; n < 8; n++) begin
        n_total++;
        if (act_hex(n) !== exp_hex[n])
          $display("FAIL rand%0d_hex%0d (v=%h m=%b): got %h want %h", it, n, v, m, act_hex(n), exp_hex[n]);
        else n_pass++;
      end
      n_total++;
      if (overflow !== exp_ovf) $display("FAIL rand%0d_ovf: got %b want %b", it, overflow, exp_ovf);
      else n_pass++;
      prev_v = v;
      prev_m = m;
    end
  endtask

  initial begin
    test_reset();
    test_hex_mode();
    test_decimal();
    test_max_value();
    test_mid_change();
    test_reset_mid_shift();
    test_mode_toggle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
